// File: rtl/vx_run_ctrl.sv
// vx_run_ctrl: APB-programmed run controller placed in front of the Vortex AXI
// wrapper. It holds the memory base offset, sequences core reset / clock
// enable / run / completion from a software START command, counts run cycles,
// enforces an optional watchdog timeout and raises a sticky done interrupt.
//
// Parameters:
//   RESET_DELAY  core reset hold cycles with the core clock enabled (>= 1)
//   CNT_WIDTH    run cycle counter width (<= 32)
//
// Ports:
//   clk, reset        system clock, synchronous active-low reset
//   psel, penable,    APB slave interface; only paddr[7:0] is decoded
//   pwrite, paddr,
//   pwdata, prdata,
//   pready, pslverr
//   vx_busy           core busy status
//   vx_clk_en         core clock gate enable (registered)
//   vx_reset          core reset, active-high (registered)
//   mem_base          base offset added to core AXI addresses (registered)
//   irq               done/timeout interrupt, level (registered)
//
// Register map (byte offsets):
//   0x50 BASE     rw
//   0x54 CTRL     wo  bit0 START, bit1 ABORT (pulses), reads 0
//   0x58 STATUS   bit0 RUNNING, bit1 DONE, bit2 TIMEOUT, bits[4:3] state;
//                 writing 1 to bit1 clears DONE and TIMEOUT
//   0x5C CYCLES   ro
//   0x60 TIMEOUT  rw, 0 disables the watchdog
//
// Build option: define VX_RUN_CTRL_IRQ_EN to drive irq from DONE | TIMEOUT;
// without it irq is tied low and software polls STATUS.

module vx_run_ctrl #(
    parameter int RESET_DELAY = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic        vx_busy,
    output logic        vx_clk_en,
    output logic        vx_reset,
    output logic [31:0] mem_base,
    output logic        irq
);

    localparam int            RW       = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RESET_DELAY - 1);

    localparam logic [7:0] OFF_BASE    = 8'h50;
    localparam logic [7:0] OFF_CTRL    = 8'h54;
    localparam logic [7:0] OFF_STATUS  = 8'h58;
    localparam logic [7:0] OFF_CYCLES  = 8'h5C;
    localparam logic [7:0] OFF_TIMEOUT = 8'h60;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [RW-1:0]        rst_ctr_q, rst_ctr_d;
    logic [CNT_WIDTH-1:0] cycles_q, cycles_d;
    logic [CNT_WIDTH-1:0] timeout_q, timeout_d;
    logic [31:0]          base_q, base_d;
    logic                 busy_seen_q, busy_seen_d;
    logic                 done_q, done_d;
    logic                 tmo_q, tmo_d;
    logic                 irq_q, irq_d;
    logic                 vx_reset_q, vx_reset_d;
    logic                 clk_en_q, clk_en_d;

    logic [7:0] offset;
    logic       wr_en;
    logic       rd_en;
    logic       mapped;
    logic       start;
    logic       abort;
    logic       status_clr;
    logic       running;
    logic       tmo_hit;
    logic       unused_addr_bits;

    assign offset           = paddr[7:0];
    assign unused_addr_bits = ^paddr[31:8];
    assign wr_en            = psel & penable & pwrite;
    assign rd_en            = psel & ~pwrite;
    assign start            = wr_en && (offset == OFF_CTRL) && pwdata[0];
    assign abort            = wr_en && (offset == OFF_CTRL) && pwdata[1];
    assign status_clr       = wr_en && (offset == OFF_STATUS) && pwdata[1];
    assign running          = (state_q == ST_RST) || (state_q == ST_RUN);

    // Watchdog fires on the run cycle whose count equals TIMEOUT-1, so the
    // counter reads exactly TIMEOUT after the final increment.
    assign tmo_hit = (timeout_q != '0) && (cycles_q == timeout_q - 1'b1);

    assign mapped = (offset == OFF_BASE) || (offset == OFF_CTRL) ||
                    (offset == OFF_STATUS) || (offset == OFF_CYCLES) ||
                    (offset == OFF_TIMEOUT);

    assign pready    = 1'b1;
    assign pslverr   = psel & penable & ~mapped;
    assign vx_clk_en = clk_en_q;
    assign vx_reset  = vx_reset_q;
    assign mem_base  = base_q;
    assign irq       = irq_q;

    always_comb begin
        prdata = '0;
        if (rd_en) begin
            case (offset)
                OFF_BASE:    prdata = base_q;
                OFF_STATUS:  prdata = {27'd0, state_q, tmo_q, done_q, running};
                OFF_CYCLES:  prdata = 32'(cycles_q);
                OFF_TIMEOUT: prdata = 32'(timeout_q);
                default:     prdata = '0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        rst_ctr_d   = rst_ctr_q;
        cycles_d    = cycles_q;
        busy_seen_d = busy_seen_q;
        done_d      = done_q;
        tmo_d       = tmo_q;
        base_d      = base_q;
        timeout_d   = timeout_q;

        if (wr_en && (offset == OFF_BASE)) begin
            base_d = pwdata;
        end
        if (wr_en && (offset == OFF_TIMEOUT)) begin
            timeout_d = pwdata[CNT_WIDTH-1:0];
        end

        // ABORT beats START beats status clear beats the FSM's own moves.
        if (abort) begin
            state_d = ST_IDLE;
        end else if (start && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
            state_d     = ST_RST;
            rst_ctr_d   = '0;
            cycles_d    = '0;
            busy_seen_d = 1'b0;
            done_d      = 1'b0;
            tmo_d       = 1'b0;
        end else begin
            case (state_q)
                ST_RST: begin
                    if (rst_ctr_q == RST_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        rst_ctr_d = rst_ctr_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cycles_q != '1) begin
                        cycles_d = cycles_q + 1'b1;
                    end
                    if (vx_busy) begin
                        busy_seen_d = 1'b1;
                    end
                    // Completion needs a busy period first, so a core that
                    // has not yet raised busy is not mistaken for finished.
                    if ((busy_seen_q && !vx_busy) || tmo_hit) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                    if (tmo_hit) begin
                        tmo_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase

            if (status_clr) begin
                done_d = 1'b0;
                tmo_d  = 1'b0;
                if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
        end

        // Core controls follow the next state so they stay in step with it.
        vx_reset_d = (state_d != ST_RUN);
        clk_en_d   = (state_d == ST_RST) || (state_d == ST_RUN);
`ifdef VX_RUN_CTRL_IRQ_EN
        irq_d      = done_d | tmo_d;
`else
        irq_d      = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rst_ctr_q   <= '0;
            cycles_q    <= '0;
            timeout_q   <= '0;
            base_q      <= '0;
            busy_seen_q <= 1'b0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
            irq_q       <= 1'b0;
            vx_reset_q  <= 1'b1;
            clk_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_ctr_q   <= rst_ctr_d;
            cycles_q    <= cycles_d;
            timeout_q   <= timeout_d;
            base_q      <= base_d;
            busy_seen_q <= busy_seen_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
            irq_q       <= irq_d;
            vx_reset_q  <= vx_reset_d;
            clk_en_q    <= clk_en_d;
        end
    end

endmodule

// File: tb/tb_vx_run_ctrl.sv
// tb_vx_run_ctrl: self-checking bench for vx_run_ctrl. Expected values come
// from a job-level model: for a job with busy starting at run cycle d, lasting
// l cycles and a watchdog value t, the run ends on cycle min(d+l, t-1).
`timescale 1ns/1ps

module tb_vx_run_ctrl;

    localparam int RESET_DELAY = 8;

    localparam logic [31:0] A_BASE    = 32'h50;
    localparam logic [31:0] A_CTRL    = 32'h54;
    localparam logic [31:0] A_STATUS  = 32'h58;
    localparam logic [31:0] A_CYCLES  = 32'h5C;
    localparam logic [31:0] A_TIMEOUT = 32'h60;

`ifdef VX_RUN_CTRL_IRQ_EN
    localparam logic IRQ_BUILD = 1'b1;
`else
    localparam logic IRQ_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        vx_busy = 1'b0;
    logic        vx_clk_en;
    logic        vx_reset;
    logic [31:0] mem_base;
    logic        irq;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    vx_run_ctrl #(.RESET_DELAY(RESET_DELAY), .CNT_WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .vx_busy  (vx_busy),
        .vx_clk_en(vx_clk_en),
        .vx_reset (vx_reset),
        .mem_base (mem_base),
        .irq      (irq)
    );

    // Hard stop in case something stalls the sequence.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] expStatus(input int st, input logic to, input logic done);
        logic running;
        running = (st == 1) || (st == 2);
        return (32'(st) << 3) | (32'(to) << 2) | (32'(done) << 1) | 32'(running);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // APB write; entered and left on a falling edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic readReg(input logic [31:0] addr, output logic [31:0] data, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(negedge clk);
        penable = 1'b1;
        #1;
        data = prdata;
        err  = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic checkReg(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        logic [31:0] data;
        logic        err;
        readReg(addr, data, err);
        checkOutput(tag, data, expected);
        checkOutput({tag, " pslverr"}, 32'(err), 32'd0);
    endtask

    task automatic waitResetHold(input string tag);
        for (int i = 0; i < RESET_DELAY; i++) begin
            checkOutput({tag, " rst hold"}, {30'd0, vx_reset, vx_clk_en}, 32'd3);
            @(negedge clk);
        end
    endtask

    // One full job: program watchdog, START, play the busy pattern, check DONE.
    task automatic runJob(input int d, input int l, input int t, input string tag);
        int   busy_end;
        int   exit_k;
        logic exp_to;
        busy_end = d + l;
        exit_k   = busy_end;
        if ((t != 0) && (t - 1 < exit_k)) exit_k = t - 1;
        exp_to = (t != 0) && (t - 1 <= busy_end);

        applyStimulus(A_TIMEOUT, 32'(t));
        applyStimulus(A_CTRL, 32'h1);
        waitResetHold(tag);
        for (int k = 0; k <= exit_k; k++) begin
            checkOutput({tag, " run"}, {30'd0, vx_reset, vx_clk_en}, 32'd1);
            vx_busy = (k >= d) && (k < busy_end);
            @(negedge clk);
        end
        vx_busy = 1'b0;
        checkOutput({tag, " done outs"}, {29'd0, vx_reset, vx_clk_en, irq},
                    {29'd0, 1'b1, 1'b0, IRQ_BUILD});
        checkReg({tag, " cycles"}, A_CYCLES, 32'(exit_k + 1));
        checkReg({tag, " status"}, A_STATUS, expStatus(3, exp_to, 1'b1));
    endtask

    // START, run with busy held, ABORT so it lands on run cycle a.
    task automatic runAbort(input int a, input string tag);
        applyStimulus(A_TIMEOUT, 32'd0);
        applyStimulus(A_CTRL, 32'h1);
        waitResetHold(tag);
        vx_busy = 1'b1;
        for (int k = 0; k < a - 1; k++) @(negedge clk);
        applyStimulus(A_CTRL, 32'h2);
        checkOutput({tag, " abort outs"}, {29'd0, vx_reset, vx_clk_en, irq}, 32'h4);
        vx_busy = 1'b0;
        checkReg({tag, " abort status"}, A_STATUS, expStatus(0, 1'b0, 1'b0));
        checkReg({tag, " abort cycles"}, A_CYCLES, 32'(a));
    endtask

    initial begin
        logic [31:0] data;
        logic        err;
        int          d, l, t, a;

        $display("[TB] vx_run_ctrl bench, RESET_DELAY=%0d, irq build=%0d", RESET_DELAY, IRQ_BUILD);

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("reset outs", {29'd0, vx_reset, vx_clk_en, irq}, 32'h4);
        checkOutput("reset mem_base", mem_base, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        checkReg("reset status", A_STATUS, 32'h0);
        checkReg("reset cycles", A_CYCLES, 32'h0);

        // BASE register, no core activity.
        applyStimulus(A_BASE, 32'h8000_0000);
        checkReg("base readback", A_BASE, 32'h8000_0000);
        checkOutput("mem_base", mem_base, 32'h8000_0000);
        checkOutput("base idle outs", {30'd0, vx_reset, vx_clk_en}, 32'd2);
        checkReg("ctrl reads 0", A_CTRL, 32'h0);

        // Directed jobs: busy-driven completion, watchdog, watchdog of 1.
        runJob(0, 100, 0, "busy100");
        runJob(0, 1000, 50, "tmo50");
        checkReg("tmo readback", A_TIMEOUT, 32'd50);
        runJob(2, 5, 1, "tmo1");
        applyStimulus(A_STATUS, 32'h2);
        checkOutput("clear irq", 32'(irq), 32'd0);
        checkReg("clear status", A_STATUS, 32'h0);

        // Randomized jobs, sometimes restarted straight from DONE.
        for (int n = 0; n < 8; n++) begin
            d = $urandom_range(0, 4);
            l = $urandom_range(1, 40);
            t = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(2, 50);
            runJob(d, l, t, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus(A_STATUS, 32'h2);
                checkReg($sformatf("rnd%0d clr", n), A_STATUS, 32'h0);
            end
        end

        // ABORT during RUN, then a fresh run restarts the counter.
        runAbort(20, "abort20");
        a = $urandom_range(1, 40);
        runAbort(a, "abortrnd");
        runJob(0, 3, 0, "after abort");

        // ABORT and START together from DONE: abort wins, flags kept.
        applyStimulus(A_CTRL, 32'h3);
        checkOutput("abort+start outs", {29'd0, vx_reset, vx_clk_en, irq},
                    {29'd0, 1'b1, 1'b0, IRQ_BUILD});
        checkReg("abort+start status", A_STATUS, expStatus(0, 1'b0, 1'b1));
        applyStimulus(A_STATUS, 32'h2);
        checkOutput("status clr irq", 32'(irq), 32'd0);
        checkReg("status clr", A_STATUS, 32'h0);

        // Unmapped offset.
        readReg(32'h70, data, err);
        checkOutput("unmapped prdata", data, 32'h0);
        checkOutput("unmapped pslverr", 32'(err), 32'd1);

        // Reset asserted mid-run.
        applyStimulus(A_TIMEOUT, 32'd1000);
        applyStimulus(A_CTRL, 32'h1);
        waitResetHold("midreset");
        vx_busy = 1'b1;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midreset outs", {29'd0, vx_reset, vx_clk_en, irq}, 32'h4);
        checkOutput("midreset mem_base", mem_base, 32'h0);
        vx_busy = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checkReg("midreset status", A_STATUS, 32'h0);
        checkReg("midreset cycles", A_CYCLES, 32'h0);
        checkReg("midreset timeout", A_TIMEOUT, 32'h0);
        checkReg("midreset base", A_BASE, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
